// File: rtl/midi_voice_allocator.sv
// Polyphonic MIDI voice allocator: turns note/CC messages from the byte parser into per-voice
// gate/key/velocity with LRU stealing, same-note retrigger and sustain-pedal handling.
module midi_voice_allocator #(
    parameter int unsigned VOICES  = 8,
    parameter int unsigned V_WIDTH = $clog2(VOICES),
    parameter bit          OMNI    = 1'b1,
    parameter logic [3:0]  MIDI_CH = 4'd0
) (
    input  logic                  CLOCK_25,
    input  logic                  iRST_N,
    input  logic                  byteready_in,
    input  logic [7:0]            cur_status_in,
    input  logic [7:0]            midi_bytes_in,
    input  logic [7:0]            databyte_in,
    input  logic [VOICES-1:0]     voice_free_,
    output logic [VOICES-1:0]     key_on,
    output logic [8*VOICES-1:0]   key_val,
    output logic [8*VOICES-1:0]   vel_on,
    output logic [V_WIDTH:0]      active_keys,
    output logic                  sustain_on,
    output logic                  steal_evt,
    output logic                  off_note_error
);
    typedef enum logic [1:0] {StIdle, StD1, StAlloc, StCommit} state_t;

    state_t             state_q, state_d;
    logic               br_q1, br_q2, strobe, chan_ok, is_msg, note_on_msg;
    logic [3:0]         status_q, status_d;
    logic [7:0]         data1_q, data1_d, data2_q, data2_d;
    logic [VOICES-1:0]  free_s1, free_s2;
    logic [VOICES-1:0]  key_on_q, key_on_d, held_q, held_d;
    logic [7:0]         key_val_q [VOICES];
    logic [7:0]         key_val_d [VOICES];
    logic [7:0]         vel_q [VOICES];
    logic [7:0]         vel_d [VOICES];
    logic [V_WIDTH-1:0] rank_q [VOICES];
    logic [V_WIDTH-1:0] rank_d [VOICES];
    logic [V_WIDTH-1:0] alloc_q, pick_v, off_v, retrig_v, free_v, idle_v, steal_v, idle_rank;
    logic               retrig_hit, free_hit, idle_hit, off_hit, steal_pick, steal_q;
    logic               sustain_q, sustain_d, err_q, err_d, steal_evt_q, steal_evt_d;
    logic [V_WIDTH:0]   active_q, active_d;

    assign strobe      = br_q1 & ~br_q2;
    assign chan_ok     = OMNI || (cur_status_in[3:0] == MIDI_CH);
    assign is_msg      = cur_status_in[7:4] inside {4'h8, 4'h9, 4'hB};
    assign note_on_msg = (status_q == 4'h9) && (data2_q != 8'h00);

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        data1_d  = data1_q;
        data2_d  = data2_q;
        unique case (state_q)
            StIdle: begin
                if (strobe && midi_bytes_in == 8'd1 && is_msg && chan_ok) begin
                    state_d  = StD1;
                    status_d = cur_status_in[7:4];
                    data1_d  = databyte_in;
                end
            end
            StD1: begin
                if (strobe) begin
                    if (midi_bytes_in == 8'd1 && is_msg && chan_ok) begin
                        status_d = cur_status_in[7:4];
                        data1_d  = databyte_in;
                    end else if (midi_bytes_in == 8'd2 && chan_ok &&
                                 cur_status_in[7:4] == status_q) begin
                        data2_d = databyte_in;
                        state_d = (status_q == 4'h9 && databyte_in != 8'h00) ? StAlloc : StCommit;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StAlloc:  state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Voice selection candidates; descending scans leave the lowest matching index.
    always_comb begin
        retrig_hit = 1'b0; retrig_v = '0;
        free_hit   = 1'b0; free_v   = '0;
        off_hit    = 1'b0; off_v    = '0;
        idle_hit   = 1'b0; idle_v   = '0; idle_rank = '0;
        steal_v    = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (key_val_q[i] == data1_q) begin
                retrig_hit = 1'b1; retrig_v = V_WIDTH'(i);
            end
            if (!key_on_q[i] && free_s2[i]) begin
                free_hit = 1'b1; free_v = V_WIDTH'(i);
            end
            if (key_on_q[i] && key_val_q[i] == data1_q) begin
                off_hit = 1'b1; off_v = V_WIDTH'(i);
            end
        end
        for (int i = 0; i < VOICES; i++) begin
            if (!key_on_q[i] && (!idle_hit || rank_q[i] > idle_rank)) begin
                idle_hit = 1'b1; idle_v = V_WIDTH'(i); idle_rank = rank_q[i];
            end
            if (rank_q[i] == V_WIDTH'(VOICES - 1)) steal_v = V_WIDTH'(i);
        end
        steal_pick = 1'b0;
        if (retrig_hit)    pick_v = retrig_v;
        else if (free_hit) pick_v = free_v;
        else if (idle_hit) pick_v = idle_v;
        else begin
            pick_v     = steal_v;
            steal_pick = 1'b1;
        end
    end

    always_comb begin
        key_on_d    = key_on_q;
        key_val_d   = key_val_q;
        vel_d       = vel_q;
        held_d      = held_q;
        rank_d      = rank_q;
        sustain_d   = sustain_q;
        err_d       = err_q;
        steal_evt_d = 1'b0;
        if (state_q == StCommit) begin
            if (note_on_msg) begin
                key_on_d[alloc_q]  = 1'b1;
                key_val_d[alloc_q] = data1_q;
                vel_d[alloc_q]     = data2_q;
                held_d[alloc_q]    = 1'b0;
                steal_evt_d        = steal_q;
                for (int i = 0; i < VOICES; i++) begin
                    if (rank_q[i] < rank_q[alloc_q]) rank_d[i] = rank_q[i] + 1'b1;
                end
                rank_d[alloc_q] = '0;
            end else if (status_q == 4'h8 || status_q == 4'h9) begin
                if (!off_hit) begin
                    err_d = 1'b1;
                end else if (sustain_q) begin
                    held_d[off_v] = 1'b1;
                end else begin
                    key_on_d[off_v]  = 1'b0;
                    key_val_d[off_v] = 8'hFF;
                    vel_d[off_v]     = data2_q;
                    held_d[off_v]    = 1'b0;
                end
            end else if (data1_q == 8'd64) begin
                sustain_d = data2_q >= 8'd64;
                if (data2_q < 8'd64) begin
                    for (int i = 0; i < VOICES; i++) begin
                        if (held_q[i]) begin
                            key_on_d[i]  = 1'b0;
                            key_val_d[i] = 8'hFF;
                        end
                    end
                    held_d = '0;
                end
            end else if (data1_q == 8'd123) begin
                key_on_d = '0;
                held_d   = '0;
                err_d    = 1'b0;
                for (int i = 0; i < VOICES; i++) begin
                    key_val_d[i] = 8'hFF;
                    vel_d[i]     = 8'h00;
                end
            end
        end
        active_d = '0;
        for (int i = 0; i < VOICES; i++) active_d = active_d + (V_WIDTH + 1)'(key_on_d[i]);
    end

    always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= StIdle;
            br_q1       <= 1'b0;
            br_q2       <= 1'b0;
            status_q    <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            free_s1     <= '0;
            free_s2     <= '0;
            key_on_q    <= '0;
            held_q      <= '0;
            alloc_q     <= '0;
            steal_q     <= 1'b0;
            sustain_q   <= 1'b0;
            err_q       <= 1'b0;
            steal_evt_q <= 1'b0;
            active_q    <= '0;
            for (int i = 0; i < VOICES; i++) begin
                key_val_q[i] <= 8'hFF;
                vel_q[i]     <= 8'h00;
                rank_q[i]    <= V_WIDTH'(i);
            end
        end else begin
            state_q     <= state_d;
            br_q1       <= byteready_in;
            br_q2       <= br_q1;
            status_q    <= status_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            free_s1     <= voice_free_;
            free_s2     <= free_s1;
            key_on_q    <= key_on_d;
            held_q      <= held_d;
            sustain_q   <= sustain_d;
            err_q       <= err_d;
            steal_evt_q <= steal_evt_d;
            active_q    <= active_d;
            key_val_q   <= key_val_d;
            vel_q       <= vel_d;
            rank_q      <= rank_d;
            if (state_q == StAlloc) begin
                alloc_q <= pick_v;
                steal_q <= steal_pick;
            end
        end
    end

    for (genvar g = 0; g < VOICES; g++) begin : g_out
        assign key_val[8*g +: 8] = key_val_q[g];
        assign vel_on[8*g +: 8]  = vel_q[g];
    end

    assign key_on         = key_on_q;
    assign active_keys    = active_q;
    assign sustain_on     = sustain_q;
    assign steal_evt      = steal_evt_q;
    assign off_note_error = err_q;
endmodule
